klp32_pipe_ctrl: RTL and testbench

Parametrised pipeline control unit for the five-stage KLP32 core (F, D, E, M, W). It tracks register hazards, generates stall, bubble and flush strobes for the inter-stage registers, and produces registered operand-forwarding selects for the execute stage. It also sequences multi-cycle memory waits with a timeout fault and keeps stall/flush performance counters. It sits beside the datapath in the core top and only drives control: no datapath values pass through it.

---
 rtl/klp32_pkg.sv | 24 ++
 rtl/klp32_pipe_ctrl_if.sv | 61 ++++++
 rtl/klp32_hazard_match.sv | 14 +
 rtl/klp32_pipe_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_klp32_pipe_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/klp32_pkg.sv
// Shared types and constants for the KLP32 pipeline control slice.
package klp32_pkg;

  // Operand source for the instruction currently in E.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_t;

  // Memory-wait sequencer states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } pipe_state_t;

  // addi x0, x0, 0 -- the canonical bubble the datapath loads on bubble/flush.
  localparam logic [31:0] KLP32_NOP = 32'h0000_0013;

  // Wide enough for timeouts up to 255 cycles.
  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/klp32_pipe_ctrl_if.sv
// Control bundle between the KLP32 datapath (master) and the pipeline control unit (slave).
interface klp32_pipe_ctrl_if
  import klp32_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              i_d_valid;
  logic              i_d_rs1_used;
  logic              i_d_rs2_used;
  logic [REG_AW-1:0] i_d_rs1;
  logic [REG_AW-1:0] i_d_rs2;
  logic              i_e_valid;
  logic              i_e_reg_wr_en;
  logic              i_e_is_load;
  logic [REG_AW-1:0] i_e_rd;
  logic              i_m_valid;
  logic              i_m_reg_wr_en;
  logic [REG_AW-1:0] i_m_rd;
  logic              i_w_valid;
  logic              i_w_reg_wr_en;
  logic [REG_AW-1:0] i_w_rd;
  logic              i_e_redirect;
  logic              i_mem_req;
  logic              i_mem_ready;

  logic              o_stall_f;
  logic              o_stall_d;
  logic              o_stall_e;
  logic              o_stall_m;
  logic              o_flush_fd;
  logic              o_bubble_de;
  logic              o_bubble_mw;
  fwd_sel_t          o_fwd_a_sel;
  fwd_sel_t          o_fwd_b_sel;
  logic              o_fault;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_flush_cnt;

  modport master (
    output i_d_valid, i_d_rs1_used, i_d_rs2_used, i_d_rs1, i_d_rs2,
           i_e_valid, i_e_reg_wr_en, i_e_is_load, i_e_rd,
           i_m_valid, i_m_reg_wr_en, i_m_rd,
           i_w_valid, i_w_reg_wr_en, i_w_rd,
           i_e_redirect, i_mem_req, i_mem_ready,
    input  o_stall_f, o_stall_d, o_stall_e, o_stall_m,
           o_flush_fd, o_bubble_de, o_bubble_mw,
           o_fwd_a_sel, o_fwd_b_sel, o_fault, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_d_valid, i_d_rs1_used, i_d_rs2_used, i_d_rs1, i_d_rs2,
           i_e_valid, i_e_reg_wr_en, i_e_is_load, i_e_rd,
           i_m_valid, i_m_reg_wr_en, i_m_rd,
           i_w_valid, i_w_reg_wr_en, i_w_rd,
           i_e_redirect, i_mem_req, i_mem_ready,
    output o_stall_f, o_stall_d, o_stall_e, o_stall_m,
           o_flush_fd, o_bubble_de, o_bubble_mw,
           o_fwd_a_sel, o_fwd_b_sel, o_fault, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/klp32_hazard_match.sv
// One source-register vs one writer-stage comparison; x0 never matches.
module klp32_hazard_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  logic              wr_valid,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] rd,
  output logic              match
);
  // The writer really produces the register the reader really needs.
  assign match = wr_valid & wr_en & rs_used & (rd == rs) & (rs != '0);
endmodule

// File: rtl/klp32_pipe_ctrl.sv
// KLP32 pipeline control: hazard stalls, redirect flushes, forwarding selects,
// memory-wait sequencing with timeout fault, and stall/flush perf counters.
module klp32_pipe_ctrl
  import klp32_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         reset,
  klp32_pipe_ctrl_if.slave pc
);
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

  // Reader side (index 0 = rs1, 1 = rs2) and writer side (0 = E, 1 = M, 2 = W).
  logic [REG_AW-1:0] rs_arr   [2];
  logic              used_arr [2];
  logic              st_valid [3];
  logic              st_wr    [3];
  logic [REG_AW-1:0] st_rd    [3];
  logic [5:0]        match_vec;  // bit = stage*2 + rs

  // An invalid decode slot has no real operands, so it can never cause a hazard.
  assign rs_arr[0]   = pc.i_d_rs1;
  assign rs_arr[1]   = pc.i_d_rs2;
  assign used_arr[0] = pc.i_d_valid & pc.i_d_rs1_used;
  assign used_arr[1] = pc.i_d_valid & pc.i_d_rs2_used;
  assign st_valid[0] = pc.i_e_valid;
  assign st_valid[1] = pc.i_m_valid;
  assign st_valid[2] = pc.i_w_valid;
  assign st_wr[0]    = pc.i_e_reg_wr_en;
  assign st_wr[1]    = pc.i_m_reg_wr_en;
  assign st_wr[2]    = pc.i_w_reg_wr_en;
  assign st_rd[0]    = pc.i_e_rd;
  assign st_rd[1]    = pc.i_m_rd;
  assign st_rd[2]    = pc.i_w_rd;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_match
      klp32_hazard_match #(.REG_AW(REG_AW)) u_match (
        .rs       (rs_arr[gi % 2]),
        .rs_used  (used_arr[gi % 2]),
        .wr_valid (st_valid[gi / 2]),
        .wr_en    (st_wr[gi / 2]),
        .rd       (st_rd[gi / 2]),
        .match    (match_vec[gi])
      );
    end
  endgenerate

  logic load_use;
  logic hazard_stall;
  assign load_use     = (match_vec[0] | match_vec[1]) & pc.i_e_is_load;
  assign hazard_stall = (FWD_EN != 0) ? load_use : (|match_vec);

  pipe_state_t           state_reg, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [WAIT_CNT_W-1:0] miss_cnt;
  logic                  mem_wait;

  // Cycles where the M-stage access is outstanding and not completing.
  assign mem_wait = ((state_reg == RUN) & pc.i_mem_req & ~pc.i_mem_ready) |
                    ((state_reg == MEM_WAIT) & ~pc.i_mem_ready);
  assign miss_cnt = wait_cnt_reg + 1'b1;

  // State register: memory-wait sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next state: wait_cnt holds the number of consecutive not-ready cycles so far.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        if (pc.i_mem_req & ~pc.i_mem_ready) begin
          if (MEM_TIMEOUT <= 1) begin
            state_next = FAULT;
          end else begin
            state_next    = MEM_WAIT;
            wait_cnt_next = WAIT_CNT_W'(1);
          end
        end else begin
          wait_cnt_next = '0;
        end
      end
      MEM_WAIT: begin
        // Ready on the timeout cycle still completes the access.
        if (pc.i_mem_ready) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (miss_cnt >= TIMEOUT_CNT) begin
          state_next = FAULT;
        end else begin
          wait_cnt_next = miss_cnt;
        end
      end
      FAULT:   state_next = FAULT;
      default: state_next = RUN;
    endcase
  end

  logic     stall_f, stall_d, stall_e, stall_m;
  logic     flush_fd, bubble_de, bubble_mw;
  fwd_sel_t fwd_a_next, fwd_b_next;

  // Outputs: strobes by priority FAULT > memory wait > redirect > hazard.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_fd  = 1'b0;
    bubble_de = 1'b0;
    bubble_mw = 1'b0;
    if (state_reg == FAULT) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
    end else if (mem_wait) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      bubble_mw = 1'b1;
    end else if (pc.i_e_redirect) begin
      flush_fd  = 1'b1;
      bubble_de = 1'b1;
    end else if (hazard_stall) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      bubble_de = 1'b1;
    end
  end

  // Forward selects for whatever enters E next: hold while E stalls, RF on bubble.
  always_comb begin
    fwd_a_next = pc.o_fwd_a_sel;
    fwd_b_next = pc.o_fwd_b_sel;
    if (!stall_e) begin
      if (bubble_de || (FWD_EN == 0)) begin
        fwd_a_next = FWD_RF;
        fwd_b_next = FWD_RF;
      end else begin
        fwd_a_next = match_vec[0] ? FWD_M : (match_vec[2] ? FWD_W : FWD_RF);
        fwd_b_next = match_vec[1] ? FWD_M : (match_vec[3] ? FWD_W : FWD_RF);
      end
    end
  end

  // Registered outputs: selects, sticky fault flag, wrapping perf counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc.o_fwd_a_sel <= FWD_RF;
      pc.o_fwd_b_sel <= FWD_RF;
      pc.o_fault     <= 1'b0;
      pc.o_stall_cnt <= '0;
      pc.o_flush_cnt <= '0;
    end else begin
      pc.o_fwd_a_sel <= fwd_a_next;
      pc.o_fwd_b_sel <= fwd_b_next;
      pc.o_fault     <= (state_next == FAULT);
      pc.o_stall_cnt <= pc.o_stall_cnt + {{(CNT_W-1){1'b0}}, stall_d};
      pc.o_flush_cnt <= pc.o_flush_cnt + {{(CNT_W-1){1'b0}}, flush_fd};
    end
  end

  assign pc.o_stall_f   = stall_f;
  assign pc.o_stall_d   = stall_d;
  assign pc.o_stall_e   = stall_e;
  assign pc.o_stall_m   = stall_m;
  assign pc.o_flush_fd  = flush_fd;
  assign pc.o_bubble_de = bubble_de;
  assign pc.o_bubble_mw = bubble_mw;

endmodule

// File: tb/tb_klp32_pipe_ctrl.sv
// Bench for klp32_pipe_ctrl: a forwarding instance (timeout 15) and an interlock
// instance (timeout 4) see the same stimulus and are compared to a cycle model.
module tb_klp32_pipe_ctrl;
  import klp32_pkg::*;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;
  localparam int TMO0   = 15;
  localparam int TMO1   = 4;

  typedef struct packed {
    logic d_valid, d_rs1_used, d_rs2_used;
    logic [4:0] d_rs1, d_rs2;
    logic e_valid, e_wr, e_load;
    logic [4:0] e_rd;
    logic m_valid, m_wr;
    logic [4:0] m_rd;
    logic w_valid, w_wr;
    logic [4:0] w_rd;
    logic redirect, mem_req, mem_ready;
  } stim_t;

  logic  clk = 1'b0;
  logic  reset;
  stim_t st;

  always #5 clk = ~clk;

  klp32_pipe_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus0 ();
  klp32_pipe_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus1 ();

  assign {bus0.i_d_valid, bus0.i_d_rs1_used, bus0.i_d_rs2_used, bus0.i_d_rs1, bus0.i_d_rs2,
          bus0.i_e_valid, bus0.i_e_reg_wr_en, bus0.i_e_is_load, bus0.i_e_rd,
          bus0.i_m_valid, bus0.i_m_reg_wr_en, bus0.i_m_rd,
          bus0.i_w_valid, bus0.i_w_reg_wr_en, bus0.i_w_rd,
          bus0.i_e_redirect, bus0.i_mem_req, bus0.i_mem_ready} = st;
  assign {bus1.i_d_valid, bus1.i_d_rs1_used, bus1.i_d_rs2_used, bus1.i_d_rs1, bus1.i_d_rs2,
          bus1.i_e_valid, bus1.i_e_reg_wr_en, bus1.i_e_is_load, bus1.i_e_rd,
          bus1.i_m_valid, bus1.i_m_reg_wr_en, bus1.i_m_rd,
          bus1.i_w_valid, bus1.i_w_reg_wr_en, bus1.i_w_rd,
          bus1.i_e_redirect, bus1.i_mem_req, bus1.i_mem_ready} = st;

  klp32_pipe_ctrl #(.REG_AW(REG_AW), .FWD_EN(1), .MEM_TIMEOUT(TMO0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .reset(reset), .pc(bus0));
  klp32_pipe_ctrl #(.REG_AW(REG_AW), .FWD_EN(0), .MEM_TIMEOUT(TMO1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .reset(reset), .pc(bus1));

  int checks = 0;
  int errors = 0;

  // Reference state per instance.
  int          miss    [2];
  bit          faulted [2];
  logic [1:0]  fa      [2];
  logic [1:0]  fb      [2];
  logic [31:0] scnt    [2];
  logic [31:0] fcnt    [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctl_of(input int k);
    if (k == 0)
      return {bus0.o_stall_f, bus0.o_stall_d, bus0.o_stall_e, bus0.o_stall_m,
              bus0.o_flush_fd, bus0.o_bubble_de, bus0.o_bubble_mw};
    return {bus1.o_stall_f, bus1.o_stall_d, bus1.o_stall_e, bus1.o_stall_m,
            bus1.o_flush_fd, bus1.o_bubble_de, bus1.o_bubble_mw};
  endfunction

  function automatic logic [3:0] fwd_of(input int k);
    if (k == 0) return {bus0.o_fwd_a_sel, bus0.o_fwd_b_sel};
    return {bus1.o_fwd_a_sel, bus1.o_fwd_b_sel};
  endfunction

  function automatic logic [64:0] regs_of(input int k);
    if (k == 0) return {bus0.o_fault, bus0.o_stall_cnt, bus0.o_flush_cnt};
    return {bus1.o_fault, bus1.o_stall_cnt, bus1.o_flush_cnt};
  endfunction

  // Does the decode operand rs depend on a pending write from this writer?
  function automatic bit needs(input logic [4:0] rs, input logic used,
                               input logic valid, input logic wr, input logic [4:0] rd);
    return st.d_valid && used && (rs != 0) && valid && wr && (rd == rs);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      miss[k] = 0; faulted[k] = 0; fa[k] = 0; fb[k] = 0; scnt[k] = 0; fcnt[k] = 0;
    end
  endtask

  // Compare one cycle at the falling edge, advance the model, return at posedge+1.
  task automatic run_cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit fwd_en = (k == 0);
      int tmo = (k == 0) ? TMO0 : TMO1;
      bit e1 = needs(st.d_rs1, st.d_rs1_used, st.e_valid, st.e_wr, st.e_rd);
      bit e2 = needs(st.d_rs2, st.d_rs2_used, st.e_valid, st.e_wr, st.e_rd);
      bit m1 = needs(st.d_rs1, st.d_rs1_used, st.m_valid, st.m_wr, st.m_rd);
      bit m2 = needs(st.d_rs2, st.d_rs2_used, st.m_valid, st.m_wr, st.m_rd);
      bit w1 = needs(st.d_rs1, st.d_rs1_used, st.w_valid, st.w_wr, st.w_rd);
      bit w2 = needs(st.d_rs2, st.d_rs2_used, st.w_valid, st.w_wr, st.w_rd);
      bit waiting = !faulted[k] && !st.mem_ready && (miss[k] > 0 || st.mem_req);
      bit hazard = fwd_en ? (st.e_load && (e1 || e2)) : (e1 || e2 || m1 || m2 || w1 || w2);
      logic [6:0] exp_ctl;
      if (faulted[k])        exp_ctl = 7'b1111000;
      else if (waiting)      exp_ctl = 7'b1111001;
      else if (st.redirect)  exp_ctl = 7'b0000110;
      else if (hazard)       exp_ctl = 7'b1100010;
      else                   exp_ctl = 7'b0000000;
      check_eq(k == 0 ? "ctl0" : "ctl1", 64'(ctl_of(k)), 64'(exp_ctl));
      check_eq(k == 0 ? "fwd0" : "fwd1", 64'(fwd_of(k)), 64'({fa[k], fb[k]}));
      check_eq(k == 0 ? "regs0" : "regs1", 64'(regs_of(k)), {faulted[k], scnt[k], fcnt[k]});
      // Advance.
      scnt[k] = scnt[k] + 32'(exp_ctl[5]);
      fcnt[k] = fcnt[k] + 32'(exp_ctl[2]);
      if (!faulted[k] && !waiting) begin
        if (st.redirect || hazard || !fwd_en) begin
          fa[k] = 2'b00; fb[k] = 2'b00;
        end else begin
          fa[k] = e1 ? 2'b01 : (m1 ? 2'b10 : 2'b00);
          fb[k] = e2 ? 2'b01 : (m2 ? 2'b10 : 2'b00);
        end
      end
      if (!faulted[k]) begin
        if (waiting) begin
          miss[k]++;
          if (miss[k] >= tmo) faulted[k] = 1;
        end else begin
          miss[k] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; registered outputs must clear at once.
  task automatic do_reset();
    st = '0;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("rst_regs0", 64'(regs_of(0)), 64'd0);
    check_eq("rst_regs1", 64'(regs_of(1)), 64'd0);
    check_eq("rst_fwd0", 64'(fwd_of(0)), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    st = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    run_cycle();

    $display("tp1: E addi writes x1, D reads x1");
    st = '0;
    st.e_valid = 1; st.e_wr = 1; st.e_rd = 5'd1;
    st.d_valid = 1; st.d_rs1_used = 1; st.d_rs1 = 5'd1;
    run_cycle();
    check_eq("tp1_fwd_a", 64'(bus0.o_fwd_a_sel), 64'd1);
    st = '0;
    run_cycle();

    $display("tp2: lw x5 in E, D add x6,x5,x5");
    do_reset();
    st = '0;
    st.e_valid = 1; st.e_wr = 1; st.e_load = 1; st.e_rd = 5'd5;
    st.d_valid = 1; st.d_rs1_used = 1; st.d_rs2_used = 1; st.d_rs1 = 5'd5; st.d_rs2 = 5'd5;
    run_cycle();
    st.e_valid = 0; st.e_wr = 0; st.e_load = 0; st.e_rd = 5'd0;
    st.m_valid = 1; st.m_wr = 1; st.m_rd = 5'd5;
    run_cycle();
    check_eq("tp2_fwd", 64'(fwd_of(0)), 64'h0a);
    check_eq("tp2_scnt", 64'(bus0.o_stall_cnt), 64'd1);

    $display("tp3: D reads x0 while E writes x0");
    st = '0;
    st.e_valid = 1; st.e_wr = 1; st.e_load = 1;
    st.d_valid = 1; st.d_rs1_used = 1; st.d_rs2_used = 1;
    run_cycle();
    run_cycle();

    $display("tp4: redirect with load-use match");
    do_reset();
    st = '0;
    st.e_valid = 1; st.e_wr = 1; st.e_load = 1; st.e_rd = 5'd7;
    st.d_valid = 1; st.d_rs1_used = 1; st.d_rs1 = 5'd7; st.redirect = 1;
    run_cycle();
    check_eq("tp4_fcnt", 64'(bus0.o_flush_cnt), 64'd1);
    check_eq("tp4_scnt", 64'(bus0.o_stall_cnt), 64'd0);

    $display("tp5: memory wait 3 cycles then ready");
    st = '0;
    st.mem_req = 1;
    repeat (3) run_cycle();
    st.mem_ready = 1;
    run_cycle();
    st = '0;
    run_cycle();

    $display("tp6: interlock writer x3 through E, M, W");
    st = '0;
    st.d_valid = 1; st.d_rs1_used = 1; st.d_rs1 = 5'd3;
    st.e_valid = 1; st.e_wr = 1; st.e_rd = 5'd3;
    run_cycle();
    st.e_valid = 0; st.m_valid = 1; st.m_wr = 1; st.m_rd = 5'd3;
    run_cycle();
    st.m_valid = 0; st.w_valid = 1; st.w_wr = 1; st.w_rd = 5'd3;
    run_cycle();
    st.w_valid = 0;
    run_cycle();
    check_eq("tp6_fwd1", 64'(fwd_of(1)), 64'd0);

    $display("tp7: reset in the middle of a memory wait");
    st = '0;
    st.mem_req = 1;
    repeat (2) run_cycle();
    do_reset();
    run_cycle();

    $display("tp8: ready never rises, both instances time out");
    st = '0;
    st.mem_req = 1;
    repeat (TMO0 + 2) run_cycle();
    check_eq("tp8_fault0", 64'(bus0.o_fault), 64'd1);
    st.mem_ready = 1;
    repeat (2) run_cycle();
    check_eq("tp8_sticky1", 64'(bus1.o_fault), 64'd1);
    do_reset();
    check_eq("tp8_cleared0", 64'(bus0.o_fault), 64'd0);
    run_cycle();

    $display("random: 3000 cycles");
    for (int n = 0; n < 3000; n++) begin
      st.d_valid    = ($urandom_range(7) != 0);
      st.d_rs1_used = $urandom_range(1);
      st.d_rs2_used = $urandom_range(1);
      st.d_rs1      = 5'($urandom_range(3));
      st.d_rs2      = 5'($urandom_range(3));
      st.e_valid    = $urandom_range(1);
      st.e_wr       = $urandom_range(1);
      st.e_load     = ($urandom_range(2) == 0);
      st.e_rd       = 5'($urandom_range(3));
      st.m_valid    = $urandom_range(1);
      st.m_wr       = $urandom_range(1);
      st.m_rd       = 5'($urandom_range(3));
      st.w_valid    = $urandom_range(1);
      st.w_wr       = $urandom_range(1);
      st.w_rd       = 5'($urandom_range(3));
      st.redirect   = ($urandom_range(9) == 0);
      st.mem_req    = ($urandom_range(5) == 0);
      st.mem_ready  = (miss[0] >= 2 || miss[1] >= 2) ? 1'b1 : ($urandom_range(2) == 0);
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
